// File: rtl/ahb_apb_arbiter.sv
// ahb_apb_arbiter: shares one AHB2APB bridge slave port between NUM_M AHB-lite
// masters. Round-robin grant with a per-tenure beat limit; address/control are
// muxed by the address-phase owner, write data by the data-phase owner, and the
// bridge response is broadcast to everyone.
// Optional build macro ARB_FIXED_PRIO_EN: lowest-index requester wins at every
// arbitration point instead of round-robin (beat-limit release still applies).
module ahb_apb_arbiter #(
  parameter int NUM_M     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic                    hclk,
  input  logic                    hreset_n,
  input  logic [NUM_M-1:0]        hbusreq,
  output logic [NUM_M-1:0]        hgrant,
  output logic [1:0]              hmaster,
  input  logic [NUM_M*ADDR_W-1:0] m_haddr,
  input  logic [NUM_M*2-1:0]      m_htrans,
  input  logic [NUM_M-1:0]        m_hwrite,
  input  logic [NUM_M*DATA_W-1:0] m_hwdata,
  output logic [ADDR_W-1:0]       s_haddr,
  output logic [1:0]              s_htrans,
  output logic                    s_hwrite,
  output logic [DATA_W-1:0]       s_hwdata,
  input  logic                    s_hready,
  input  logic [DATA_W-1:0]       s_hrdata,
  input  logic                    s_hresp,
  output logic                    hready,
  output logic [DATA_W-1:0]       hrdata,
  output logic                    hresp
);

  localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

  logic [NUM_M-1:0] r_hgrant;
  logic [1:0]       r_hmaster;
  logic [1:0]       r_hmasterD;
  logic [CNT_W-1:0] r_cnt;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]       r_ptr;
  logic [NUM_M-1:0] w_sel;
`endif

  logic [NUM_M-1:0] w_ownerOh;
  logic [1:0]       w_grantIdx;
  logic             w_ownerActive;
  logic             w_otherReq;
  logic             w_forced;
  logic             w_arb;
  logic [NUM_M-1:0] w_cand;
  logic [NUM_M-1:0] w_nextGrant;
  logic             w_found;

  assign hgrant  = r_hgrant;
  assign hmaster = r_hmaster;
  assign hready  = s_hready;
  assign hrdata  = s_hrdata;
  assign hresp   = s_hresp;

  // Bridge-side muxes plus one-hot/index conversions of owner and grant.
  always_comb begin
    s_haddr    = '0;
    s_htrans   = 2'b00;
    s_hwrite   = 1'b0;
    s_hwdata   = '0;
    w_ownerOh  = '0;
    w_grantIdx = 2'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_hmaster == 2'(i)) begin
        s_haddr      = m_haddr[i*ADDR_W +: ADDR_W];
        s_htrans     = m_htrans[i*2 +: 2];
        s_hwrite     = m_hwrite[i];
        w_ownerOh[i] = 1'b1;
      end
      if (r_hmasterD == 2'(i)) begin
        s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
      end
      if (r_hgrant[i]) begin
        w_grantIdx = 2'(i);
      end
    end
  end

  // A forced release skips the owner so the limit cannot be undone by the
  // beat the losing owner still issues before ownership actually moves.
  assign w_ownerActive = s_htrans[1];
  assign w_otherReq    = |(hbusreq & ~w_ownerOh);
  assign w_forced      = w_ownerActive && (r_cnt == CNT_MAX) && w_otherReq;
  assign w_arb         = s_hready && (!w_ownerActive || w_forced);
  assign w_cand        = hbusreq & ~(w_forced ? w_ownerOh : '0);

  // Next-grant selection; with no candidate the grant stays where it is.
  always_comb begin
    w_nextGrant = r_hgrant;
    w_found     = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_cand[i]) begin
        w_nextGrant    = '0;
        w_nextGrant[i] = 1'b1;
        w_found        = 1'b1;
      end
    end
`else
    w_sel = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      w_sel = NUM_M'(1) << ((int'(r_ptr) + k) % NUM_M);
      if (!w_found && (|(w_cand & w_sel))) begin
        w_nextGrant = w_sel;
        w_found     = 1'b1;
      end
    end
`endif
  end

  // Grant and address/data-phase ownership advance only on hready edges.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_hgrant   <= NUM_M'(1);
      r_hmaster  <= 2'd0;
      r_hmasterD <= 2'd0;
    end else if (s_hready) begin
      if (w_arb) begin
        r_hgrant <= w_nextGrant;
      end
      r_hmaster  <= w_grantIdx;
      r_hmasterD <= r_hmaster;
    end
  end

  // Beat counter: restarts on owner change or IDLE, saturates at the limit.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_cnt <= '0;
    end else if (s_hready) begin
      if (w_grantIdx != r_hmaster) begin
        r_cnt <= '0;
      end else if (s_htrans == 2'b00) begin
        r_cnt <= '0;
      end else if (w_ownerActive && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin pointer follows the newest address-phase owner.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_ptr <= 2'd0;
    end else if (s_hready && (w_grantIdx != r_hmaster)) begin
      r_ptr <= w_grantIdx;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// tb_ahb_apb_arbiter: directed bench for ahb_apb_arbiter with an integer-level
// reference model and hand-computed literal checkpoints.
module tb_ahb_apb_arbiter;

  localparam int NUM_M     = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 8;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic                    hclk = 1'b0;
  logic                    hreset_n;
  logic [NUM_M-1:0]        hbusreq;
  logic [NUM_M-1:0]        hgrant;
  logic [1:0]              hmaster;
  logic [NUM_M*ADDR_W-1:0] m_haddr;
  logic [NUM_M*2-1:0]      m_htrans;
  logic [NUM_M-1:0]        m_hwrite;
  logic [NUM_M*DATA_W-1:0] m_hwdata;
  logic [ADDR_W-1:0]       s_haddr;
  logic [1:0]              s_htrans;
  logic                    s_hwrite;
  logic [DATA_W-1:0]       s_hwdata;
  logic                    s_hready;
  logic [DATA_W-1:0]       s_hrdata;
  logic                    s_hresp;
  logic                    hready;
  logic [DATA_W-1:0]       hrdata;
  logic                    hresp;

  logic [31:0] mAddr  [2];
  logic [1:0]  mTrans [2];
  logic        mWrite [2];
  logic [31:0] mWdata [2];

  assign m_haddr  = {mAddr[1], mAddr[0]};
  assign m_htrans = {mTrans[1], mTrans[0]};
  assign m_hwrite = {mWrite[1], mWrite[0]};
  assign m_hwdata = {mWdata[1], mWdata[0]};

  ahb_apb_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hbusreq(hbusreq), .hgrant(hgrant),
    .hmaster(hmaster), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hwdata(m_hwdata), .s_haddr(s_haddr),
    .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Reference model: who holds the grant, who owns the address and data
  // phases, where round-robin resumes, and how many beats the owner has had.
  int mGrant  = 0;
  int mOwner  = 0;
  int mOwnerD = 0;
  int mPtr    = 0;
  int mCnt    = 0;

  function automatic bit othersWant(input logic [1:0] req, input int owner);
    bit any = 0;
    for (int j = 0; j < NUM_M; j++) if (j != owner && req[j]) any = 1;
    return any;
  endfunction

  function automatic int pickGrant(input int ptr, input int owner, input int cur,
                                   input logic [1:0] req, input bit forced);
    int res = cur;
`ifdef ARB_FIXED_PRIO_EN
    for (int j = NUM_M - 1; j >= 0; j--)
      if (req[j] && !(forced && j == owner)) res = j;
`else
    for (int off = NUM_M; off >= 1; off--) begin
      int j = (ptr + off) % NUM_M;
      if (req[j] && !(forced && j == owner)) res = j;
    end
`endif
    return res;
  endfunction

  function automatic bit beatActive(input logic [1:0] t);
    return t == NONSEQ || t == SEQ;
  endfunction

  function automatic bit limitHit(input logic [1:0] t, input int cnt,
                                  input logic [1:0] req, input int owner);
    return beatActive(t) && cnt == MAX_BEATS - 1 && othersWant(req, owner);
  endfunction

  always @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      mGrant <= 0; mOwner <= 0; mOwnerD <= 0; mPtr <= 0; mCnt <= 0;
    end else if (s_hready) begin
      if (!beatActive(mTrans[mOwner]) || limitHit(mTrans[mOwner], mCnt, hbusreq, mOwner))
        mGrant <= pickGrant(mPtr, mOwner, mGrant, hbusreq,
                            limitHit(mTrans[mOwner], mCnt, hbusreq, mOwner));
      mOwner  <= mGrant;
      mOwnerD <= mOwner;
      if (mGrant != mOwner) begin
        mCnt <= 0;
        mPtr <= mGrant;
      end else if (mTrans[mOwner] == IDLE) begin
        mCnt <= 0;
      end else if (beatActive(mTrans[mOwner])) begin
        mCnt <= (mCnt + 1 > MAX_BEATS - 1) ? MAX_BEATS - 1 : mCnt + 1;
      end
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge hclk) begin
    checkOutput("cyc_hgrant",   64'(hgrant),   64'(1 << mGrant));
    checkOutput("cyc_hmaster",  64'(hmaster),  64'(mOwner));
    checkOutput("cyc_s_haddr",  64'(s_haddr),  64'(mAddr[mOwner]));
    checkOutput("cyc_s_htrans", 64'(s_htrans), 64'(mTrans[mOwner]));
    checkOutput("cyc_s_hwrite", 64'(s_hwrite), 64'(mWrite[mOwner]));
    checkOutput("cyc_s_hwdata", 64'(s_hwdata), 64'(mWdata[mOwnerD]));
    checkOutput("cyc_hready",   64'(hready),   64'(s_hready));
    checkOutput("cyc_hrdata",   64'(hrdata),   64'(s_hrdata));
    checkOutput("cyc_hresp",    64'(hresp),    64'(s_hresp));
  end

  task automatic step();
    @(posedge hclk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] t0,
                               input logic [1:0] t1);
    hbusreq   = req;
    mTrans[0] = t0;
    mTrans[1] = t1;
    step();
  endtask

  logic [1:0] rrGrant [4];
  int         rrOwner [4];

  initial begin
    hreset_n  = 1'b0;
    hbusreq   = 2'b00;
    mAddr[0]  = 32'h1000_0000;  mAddr[1]  = 32'h2000_0000;
    mTrans[0] = IDLE;           mTrans[1] = IDLE;
    mWrite[0] = 1'b0;           mWrite[1] = 1'b1;
    mWdata[0] = 32'hDEAD_BEEF;  mWdata[1] = 32'h0BAD_0001;
    s_hready  = 1'b1;
    s_hrdata  = 32'h0;
    s_hresp   = 1'b0;

    applyStimulus(2'b00, IDLE, IDLE);
    checkOutput("reset_hgrant", 64'(hgrant), 64'h1);
    checkOutput("reset_hmaster", 64'(hmaster), 64'h0);
    applyStimulus(2'b00, IDLE, IDLE);
    hreset_n = 1'b1;

    // Single requester takes the grant, then ownership, then writes.
    applyStimulus(2'b10, IDLE, IDLE);
    checkOutput("single_hgrant", 64'(hgrant), 64'h2);
    checkOutput("single_hmaster_early", 64'(hmaster), 64'h0);
    applyStimulus(2'b10, IDLE, IDLE);
    checkOutput("single_hmaster", 64'(hmaster), 64'h1);
    mAddr[1]  = 32'h4000_0010;
    mWrite[1] = 1'b1;
    mTrans[1] = NONSEQ;
    #1;
    checkOutput("single_haddr", 64'(s_haddr), 64'h4000_0010);
    checkOutput("single_htrans", 64'(s_htrans), 64'h2);
    applyStimulus(2'b10, IDLE, NONSEQ);
    mWdata[1] = 32'hA5A5_5A5A;
    mTrans[1] = IDLE;
    #1;
    checkOutput("single_hwdata", 64'(s_hwdata), 64'hA5A5_5A5A);
    applyStimulus(2'b10, IDLE, IDLE);

    // Both request; master 0 becomes owner.
    applyStimulus(2'b11, IDLE, IDLE);
    checkOutput("rr_start_hgrant", 64'(hgrant), 64'h1);
    applyStimulus(2'b11, IDLE, IDLE);
    checkOutput("rr_start_hmaster", 64'(hmaster), 64'h0);

`ifdef ARB_FIXED_PRIO_EN
    rrGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
    rrOwner = '{0, 0, 0, 0};
`else
    rrGrant = '{2'b10, 2'b01, 2'b10, 2'b01};
    rrOwner = '{1, 0, 1, 0};
`endif
    for (int r = 0; r < 4; r++) begin
      int m;
      m = rrOwner[(r + 3) % 4];
      applyStimulus(2'b11, (m == 0) ? NONSEQ : IDLE, (m == 1) ? NONSEQ : IDLE);
      applyStimulus(2'b11, IDLE, IDLE);
      checkOutput("arb_hgrant", 64'(hgrant), 64'(rrGrant[r]));
      applyStimulus(2'b11, IDLE, IDLE);
      checkOutput("arb_hmaster", 64'(hmaster), 64'(rrOwner[r]));
    end

    // Master 0 bursts while master 1 waits: released after 8 beats.
    for (int k = 1; k <= 9; k++) begin
      mAddr[0] = 32'h4000_1000 + 32'(4 * k);
      applyStimulus(2'b11, (k == 1) ? NONSEQ : SEQ, IDLE);
      checkOutput("limit_hgrant", 64'(hgrant), (k >= 8) ? 64'h2 : 64'h1);
    end
    checkOutput("limit_hmaster", 64'(hmaster), 64'h1);
    applyStimulus(2'b11, IDLE, NONSEQ);
    checkOutput("limit_m1_hold", 64'(hgrant), 64'h2);
    applyStimulus(2'b11, IDLE, IDLE);
    checkOutput("limit_regain", 64'(hgrant), 64'h1);
    applyStimulus(2'b11, IDLE, IDLE);
    checkOutput("limit_regain_hmaster", 64'(hmaster), 64'h0);

    // Read stretched by three wait states; nothing may move meanwhile.
    mWrite[0] = 1'b0;
    mAddr[0]  = 32'h4000_0020;
    applyStimulus(2'b11, NONSEQ, IDLE);
    s_hready = 1'b0;
    s_hrdata = 32'hFFFF_0000;
    for (int w = 0; w < 3; w++) begin
      s_hresp = (w == 2);
      applyStimulus(2'b10, IDLE, IDLE);
      checkOutput("wait_hgrant", 64'(hgrant), 64'h1);
      checkOutput("wait_hmaster", 64'(hmaster), 64'h0);
      checkOutput("wait_hresp", 64'(hresp), (w == 2) ? 64'h1 : 64'h0);
    end
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = 32'h1234_5678;
    #1;
    checkOutput("wait_hrdata", 64'(hrdata), 64'h1234_5678);
    checkOutput("wait_hready", 64'(hready), 64'h1);
    applyStimulus(2'b10, IDLE, IDLE);
    checkOutput("after_wait_hgrant", 64'(hgrant), 64'h2);
    applyStimulus(2'b10, IDLE, IDLE);
    checkOutput("after_wait_hmaster", 64'(hmaster), 64'h1);

    // Asynchronous reset in the middle of a cycle.
    mTrans[0] = NONSEQ;
    mTrans[1] = SEQ;
    #1;
    checkOutput("pre_reset_htrans", 64'(s_htrans), 64'h3);
    hreset_n = 1'b0;
    #1;
    checkOutput("midreset_hgrant", 64'(hgrant), 64'h1);
    checkOutput("midreset_hmaster", 64'(hmaster), 64'h0);
    checkOutput("midreset_htrans", 64'(s_htrans), 64'h2);
    applyStimulus(2'b00, IDLE, IDLE);
    applyStimulus(2'b00, IDLE, IDLE);
    hreset_n = 1'b1;
    applyStimulus(2'b00, IDLE, IDLE);
    applyStimulus(2'b00, IDLE, IDLE);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
